serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder built around the team's Full_Adder cell plus a carry flip-flop and operand/result shift registers.
- Captures two WIDTH-bit operands and a carry-in on a start pulse, then resolves one bit per clock.
- Presents a registered sum and carry-out with a one-cycle done strobe.
- Sits between operand-producing logic and any consumer that trades latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle strobe: result valid.
- sum  output  WIDTH  registered result; held between completions.
- cout  output  1  registered carry-out; held between completions.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and counter are cleared.
  - Reset asserted mid-operation aborts the add; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at a rising edge loads opA<=a, opB<=b, carry<=cin, cnt<=0, and moves to RUN.
  - RUN: each edge, the bit cell adds opA[0], opB[0] and carry.
    - Bit-cell sum is shifted in at the MSB of the internal result register.
    - carry <= bit-cell CO; opA and opB shift right by one; cnt++.
    - On the edge where cnt==WIDTH-1: sum <= the final shifted result, cout <= final CO, state moves to DONE.
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE.
- Latency: with start high in cycle 0, RUN occupies cycles 1..WIDTH and done=1 in cycle WIDTH+1. Total WIDTH+1 cycles, fixed regardless of operand values.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1) on the captured values. No overflow flag; cout is the overflow.
- Boundaries:
  - start in RUN or DONE is ignored; no queuing.
  - A new start is accepted in IDLE, the cycle after DONE at the earliest, giving a throughput of one add per WIDTH+2 cycles.
  - a, b and cin changes after capture have no effect on the operation in flight.
  - sum and cout change only on the edge that enters DONE (or on reset). They are stable at all other times, including during the next RUN.
  - With WIDTH=1, RUN lasts a single cycle.
  - cnt width is $clog2(WIDTH)+1 bits, and cnt never wraps.
- All outputs are driven from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum for the state {IDLE, RUN, DONE}.
  - A localparam helper for the counter width.
- Sub-module: one instance of the existing Full_Adder (A, B, CI -> S, CO) as the bit cell. No other sub-modules.

Test Plan:
1. WIDTH=8, a=0x3C, b=0x5A, cin=0, start in cycle 0 -> busy=1 in cycles 1..9, done=1 only in cycle 9, sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0, b=0, cin=1 -> sum=0x01, cout=0.
3. Start accepted with a=0x10, b=0x20; hold start high and change a=0xAA, b=0x55 in cycles 1..9 -> exactly one done, sum=0x30, and no second operation begins before IDLE.
4. Back-to-back: 0x01+0x02, then start in the cycle after done with 0x80+0x80 -> results 0x03/cout0, then 0x00/cout1. The first result stays on sum until the second done.
5. Reset pulse (rst_n=0) in cycle 4 of an add -> busy, done, sum and cout go to 0 immediately. No done follows; a fresh start afterwards completes normally.
6. WIDTH=1 build: a=1, b=1, cin=1 -> done in cycle 2, sum=1, cout=1. Also randomised 1000-vector compare against a+b+cin for WIDTH=8 and WIDTH=13.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: $clog2(width)+1 bits, so it never wraps.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full adder cell used as the serial adder's bit slice.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, a carry flop and shift
// registers resolve {cout,sum} = a + b + cin over WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               bit_s;
    logic               bit_co;

    Full_Adder u_bit (
        .A  (op_a[0]),
        .B  (op_b[0]),
        .CI (carry),
        .S  (bit_s),
        .CO (bit_co)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Bit-cell sum enters at the MSB; written without a part-select so WIDTH=1 elaborates.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = bit_s;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so no output is decoded combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= bit_co;
                    if (last) begin
                        sum  <= res_next;
                        cout <= bit_co;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH = 8, 1 and 13.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start1 = 1'b0, cin1 = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, cout1;
    logic [0:0]  sum1;

    logic        start13 = 1'b0, cin13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0;
    logic        busy13, done13, cout13;
    logic [12:0] sum13;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic c, input string tag);
        logic [8:0] exp;
        int n;
        exp = {1'b0, x} + {1'b0, y} + 9'(c);
        @(negedge clk);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, 9);
        check({tag, ".sum"}, sum8, exp[7:0]);
        check({tag, ".cout"}, cout8, exp[8]);
    endtask

    task automatic add1(input logic x, input logic y, input logic c, input string tag);
        logic [1:0] exp;
        int n;
        exp = 2'(x) + 2'(y) + 2'(c);
        @(negedge clk);
        a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, 2);
        check({tag, ".sum"}, sum1, exp[0]);
        check({tag, ".cout"}, cout1, exp[1]);
    endtask

    task automatic add13(input logic [12:0] x, input logic [12:0] y, input logic c, input string tag);
        logic [13:0] exp;
        int n;
        exp = {1'b0, x} + {1'b0, y} + 14'(c);
        @(negedge clk);
        a13 = x; b13 = y; cin13 = c; start13 = 1'b1;
        @(negedge clk);
        start13 = 1'b0;
        n = 1;
        while (!done13 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, 14);
        check({tag, ".sum"}, sum13, exp[12:0]);
        check({tag, ".cout"}, cout13, exp[13]);
    endtask

    initial begin
        int dones;
        int hold_bad;
        int n;

        repeat (2) @(negedge clk);
        check("rst.busy", busy8, 0);
        check("rst.done", done8, 0);
        check("rst.sum", sum8, 0);
        check("rst.cout", cout8, 0);
        rst_n = 1'b1;

        // Test 1: cycle-accurate busy/done profile.
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start8 = 1'b0;
            check($sformatf("t1.busy.c%0d", cyc), busy8, (cyc <= 9) ? 1 : 0);
            check($sformatf("t1.done.c%0d", cyc), done8, (cyc == 9) ? 1 : 0);
            if (cyc == 9) begin
                check("t1.sum", sum8, 8'h96);
                check("t1.cout", cout8, 0);
            end
        end

        // Test 2: carry boundaries.
        add8(8'hFF, 8'h01, 1'b0, "t2a");
        add8(8'hFF, 8'hFF, 1'b1, "t2b");
        add8(8'h00, 8'h00, 1'b1, "t2c");

        // Test 3: start held and operands changed during the operation.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        dones = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                check("t3.sum", sum8, 8'h30);
                check("t3.cout", cout8, 0);
            end
            a8 = 8'hAA; b8 = 8'h55;
        end
        @(negedge clk);
        check("t3.idle_busy", busy8, 0);
        if (done8) dones++;
        start8 = 1'b0;
        check("t3.done_count", dones, 1);

        // Test 4: back-to-back, first result held through the second run.
        add8(8'h01, 8'h02, 1'b0, "t4a");
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        hold_bad = 0;
        while (!done8 && n < 30) begin
            if (sum8 !== 8'h03 || cout8 !== 1'b0) hold_bad++;
            @(negedge clk);
            n++;
        end
        check("t4.hold", hold_bad, 0);
        check("t4b.lat", n, 9);
        check("t4b.sum", sum8, 8'h00);
        check("t4b.cout", cout8, 1);

        // Test 5: asynchronous reset mid-operation.
        add8(8'h3C, 8'h5A, 1'b0, "t5pre");
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5.busy", busy8, 0);
        check("t5.done", done8, 0);
        check("t5.sum", sum8, 0);
        check("t5.cout", cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done8 || busy8) dones++;
        end
        check("t5.no_done", dones, 0);
        add8(8'h12, 8'h34, 1'b1, "t5post");

        // Test 6: WIDTH=1 build, all input combinations.
        add1(1'b1, 1'b1, 1'b1, "w1.111");
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            add1(bits[2], bits[1], bits[0], $sformatf("w1.%0d", v));
        end

        for (int i = 0; i < 1000; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("r8.%0d", i));
        end
        for (int i = 0; i < 1000; i++) begin
            add13(13'($urandom), 13'($urandom), 1'($urandom), $sformatf("r13.%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
